// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit path.
package usb_tx_pkg;

    // Field code presented to the NRZI line encoder for each bit period.
    typedef enum logic [2:0] {
        CODE_IDLE  = 3'd0,   // idle / J
        CODE_SYNC  = 3'd1,
        CODE_PID   = 3'd2,
        CODE_DATA  = 3'd3,
        CODE_CRC   = 3'd4,
        CODE_STUFF = 3'd5,
        CODE_EOP   = 3'd6,   // SE0
        CODE_RSVD  = 3'd7    // encoder treats as SE0
    } state_code_e;

    // Packet-level sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC,
        ST_EOP,
        ST_J
    } tx_state_e;

    localparam logic [3:0]  PID_ACK   = 4'b0010;
    localparam logic [3:0]  PID_NAK   = 4'b1010;
    localparam logic [3:0]  PID_DATA0 = 4'b0011;
    localparam logic [3:0]  PID_DATA1 = 4'b1011;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // Consecutive ones that force a stuffed zero.
    localparam logic [2:0]  STUFF_RUN  = 3'd6;

    // DATA0/DATA1/DATA2/MDATA all share the low bits 2'b11.
    function automatic logic is_data_pid(input logic [3:0] pid);
        return pid[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial CRC16 (poly 0x8005) over payload bits, MSB-side feedback.
module usb_crc16
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic fb;
    assign fb = bit_in ^ crc[15];

    // CRC register: clear has priority over a shift in the same cycle.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc <= CRC16_INIT;
        end else if (clear) begin
            crc <= CRC16_INIT;
        end else if (shift_en) begin
            crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/usb_tx_sequencer.sv
// USB full-speed transmit sequencer: bit timing, field sequencing,
// FIFO payload fetch, CRC16 and bit stuffing ahead of the NRZI encoder.
module usb_tx_sequencer
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_BYTES    = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic [6:0] tx_byte_count,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_pop,
    output logic       bit_strobe,
    output logic       serial_bit,
    output logic [2:0] state_val,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_LAST    = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_PRELAST = TW'(CLKS_PER_BIT - 2);

    tx_state_e   st_q;
    logic [TW-1:0] timer_q;
    logic [3:0]  idx_q;       // bit index within the current field
    logic [6:0]  byte_q;      // payload byte index
    logic [6:0]  count_q;     // clamped payload length
    logic [3:0]  pid_q;
    logic [7:0]  shift_q;     // current payload byte
    logic [2:0]  ones_q;      // run of consecutive transmitted ones
    logic        aborted_q;

    logic [15:0] crc;
    logic [7:0]  pid_byte;

    logic accept, advance, finish, stuff_now;

    tx_state_e   pos_st, nxt_st;
    logic [3:0]  pos_idx, nxt_idx;
    logic [6:0]  pos_byte, nxt_byte;
    state_code_e nxt_code;
    logic        nxt_bit;
    logic        take_byte, underrun, crc_shift, crc_clear;

    assign pid_byte  = {~pid_q, pid_q};
    assign accept    = tx_start && !tx_busy;
    assign advance   = (st_q inside {ST_SYNC, ST_PID, ST_DATA, ST_CRC, ST_EOP}) && (timer_q == T_LAST);
    assign finish    = (st_q == ST_J) && (timer_q == T_LAST);
    assign stuff_now = (ones_q == STUFF_RUN) && (st_q inside {ST_SYNC, ST_PID, ST_DATA, ST_CRC});

    // Decide the content of the next bit period: a stuffed zero, or the next field bit.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pos_st    = st_q;
        pos_idx   = idx_q;
        pos_byte  = byte_q;
        nxt_st    = st_q;
        nxt_idx   = idx_q;
        nxt_byte  = byte_q;
        nxt_code  = CODE_STUFF;
        nxt_bit   = 1'b0;
        take_byte = 1'b0;
        underrun  = 1'b0;
        crc_shift = 1'b0;
        crc_clear = 1'b0;

        if (!stuff_now) begin
            // Step the field position past the last real bit.
            unique case (st_q)
                ST_SYNC: begin
                    if (idx_q == 4'd7) begin
                        pos_st    = ST_PID;
                        pos_idx   = 4'd0;
                        crc_clear = 1'b1;
                    end else begin
                        pos_idx = idx_q + 4'd1;
                    end
                end
                ST_PID: begin
                    if (idx_q == 4'd7) begin
                        pos_idx = 4'd0;
                        if (!is_data_pid(pid_q)) begin
                            pos_st = ST_EOP;
                        end else if (count_q != 7'd0) begin
                            pos_st   = ST_DATA;
                            pos_byte = 7'd0;
                        end else begin
                            pos_st = ST_CRC;
                        end
                    end else begin
                        pos_idx = idx_q + 4'd1;
                    end
                end
                ST_DATA: begin
                    if (idx_q == 4'd7) begin
                        pos_idx = 4'd0;
                        if (byte_q + 7'd1 < count_q) begin
                            pos_byte = byte_q + 7'd1;
                        end else begin
                            pos_st = ST_CRC;
                        end
                    end else begin
                        pos_idx = idx_q + 4'd1;
                    end
                end
                ST_CRC: begin
                    if (idx_q == 4'd15) begin
                        pos_st  = ST_EOP;
                        pos_idx = 4'd0;
                    end else begin
                        pos_idx = idx_q + 4'd1;
                    end
                end
                ST_EOP: begin
                    if (idx_q == 4'd1) begin
                        pos_st  = ST_J;
                        pos_idx = 4'd0;
                    end else begin
                        pos_idx = idx_q + 4'd1;
                    end
                end
                default: ;
            endcase

            nxt_st   = pos_st;
            nxt_idx  = pos_idx;
            nxt_byte = pos_byte;

            // Produce the bit for the new position.
            unique case (pos_st)
                ST_SYNC: begin
                    nxt_code = CODE_SYNC;
                    nxt_bit  = (pos_idx == 4'd7);
                end
                ST_PID: begin
                    nxt_code = CODE_PID;
                    nxt_bit  = pid_byte[pos_idx[2:0]];
                end
                ST_DATA: begin
                    if (pos_idx == 4'd0 && fifo_empty) begin
                        // Underrun: abandon the payload and close the packet.
                        underrun = 1'b1;
                        nxt_st   = ST_EOP;
                        nxt_idx  = 4'd0;
                        nxt_code = CODE_EOP;
                        nxt_bit  = 1'b0;
                    end else if (pos_idx == 4'd0) begin
                        take_byte = 1'b1;
                        crc_shift = 1'b1;
                        nxt_code  = CODE_DATA;
                        nxt_bit   = fifo_data[0];
                    end else begin
                        crc_shift = 1'b1;
                        nxt_code  = CODE_DATA;
                        nxt_bit   = shift_q[pos_idx[2:0]];
                    end
                end
                ST_CRC: begin
                    nxt_code = CODE_CRC;
                    nxt_bit  = ~crc[4'd15 - pos_idx];
                end
                ST_EOP: begin
                    nxt_code = CODE_EOP;
                    nxt_bit  = 1'b0;
                end
                default: begin
                    nxt_code = CODE_IDLE;
                    nxt_bit  = 1'b1;
                end
            endcase
        end
    end

    usb_crc16 u_crc16 (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (advance && crc_clear),
        .shift_en (advance && crc_shift),
        .bit_in   (nxt_bit),
        .crc      (crc)
    );

    // Sequencer FSM with bit timer, ones counter and registered outputs.
    // NOTE: every control register has an async reset so a mid-packet reset lands in IDLE at once.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            st_q       <= ST_IDLE;
            timer_q    <= '0;
            idx_q      <= 4'd0;
            byte_q     <= 7'd0;
            count_q    <= 7'd0;
            pid_q      <= 4'd0;
            shift_q    <= 8'd0;
            ones_q     <= 3'd0;
            aborted_q  <= 1'b0;
            state_val  <= CODE_IDLE;
            serial_bit <= 1'b1;
            bit_strobe <= 1'b0;
            fifo_pop   <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
        end else begin
            bit_strobe <= 1'b0;
            fifo_pop   <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;

            if (accept) begin
                st_q       <= ST_SYNC;
                timer_q    <= '0;
                idx_q      <= 4'd0;
                byte_q     <= 7'd0;
                ones_q     <= 3'd0;
                aborted_q  <= 1'b0;
                pid_q      <= tx_pid;
                count_q    <= (int'(tx_byte_count) > MAX_BYTES) ? 7'(MAX_BYTES) : tx_byte_count;
                state_val  <= CODE_SYNC;
                serial_bit <= 1'b0;
                bit_strobe <= 1'b1;
                tx_busy    <= 1'b1;
            end else if (finish) begin
                st_q       <= ST_IDLE;
                timer_q    <= '0;
                state_val  <= CODE_IDLE;
                serial_bit <= 1'b1;
            end else if (st_q != ST_IDLE) begin
                timer_q <= (timer_q == T_LAST) ? '0 : timer_q + 1'b1;

                // Busy drops on the final clock of J, alongside tx_done.
                if (st_q == ST_J && timer_q == T_PRELAST) begin
                    tx_busy <= 1'b0;
                    tx_done <= !aborted_q;
                end

                if (advance) begin
                    st_q       <= nxt_st;
                    idx_q      <= nxt_idx;
                    byte_q     <= nxt_byte;
                    state_val  <= nxt_code;
                    serial_bit <= nxt_bit;
                    bit_strobe <= 1'b1;
                    fifo_pop   <= take_byte;
                    tx_error   <= underrun;
                    if (underrun) begin
                        aborted_q <= 1'b1;
                    end
                    if (take_byte) begin
                        shift_q <= fifo_data;
                    end
                    if (nxt_code inside {CODE_SYNC, CODE_PID, CODE_DATA, CODE_CRC}) begin
                        ones_q <= nxt_bit ? ones_q + 3'd1 : 3'd0;
                    end else begin
                        ones_q <= 3'd0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Self-checking bench for usb_tx_sequencer: a bit-period-level packet model
// is compared against the DUT outputs on every clock of every packet.
module tb_usb_tx_sequencer;
    import usb_tx_pkg::*;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [3:0] tx_pid = 4'd0;
    logic [6:0] tx_byte_count = 7'd0;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_pop, bit_strobe, serial_bit, tx_busy, tx_done, tx_error;
    logic [2:0] state_val;

    usb_tx_sequencer #(.CLKS_PER_BIT(CPB), .MAX_BYTES(64)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .tx_start      (tx_start),
        .tx_pid        (tx_pid),
        .tx_byte_count (tx_byte_count),
        .fifo_data     (fifo_data),
        .fifo_empty    (fifo_empty),
        .fifo_pop      (fifo_pop),
        .bit_strobe    (bit_strobe),
        .serial_bit    (serial_bit),
        .state_val     (state_val),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .tx_error      (tx_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One expected bus bit period.
    typedef struct {
        logic [2:0] code;
        logic       b;
        logic       pop;
        logic       err;
    } period_t;

    // One unstuffed field bit; tag = payload byte index at bit 0, else -1.
    typedef struct {
        logic [2:0] code;
        logic       b;
        int         tag;
    } raw_t;

    period_t    exp_q[$];
    logic [7:0] pkt_bytes[64];
    logic [7:0] fifo_q[$];

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    endfunction

    // Build the expected bit-period list from the packet rules.
    task automatic build_model(input logic [3:0] pid, input int count, input int avail, output int aborted);
        raw_t        raw[$];
        logic [15:0] c;
        logic [7:0]  pb;
        int          n;
        int          run;
        c = 16'hFFFF;
        exp_q.delete();
        for (int i = 0; i < 8; i++) raw.push_back('{3'd1, (i == 7), -1});
        pb = {~pid, pid};
        for (int i = 0; i < 8; i++) raw.push_back('{3'd2, pb[i], -1});
        if (pid[1:0] == 2'b11) begin
            n = (count > 64) ? 64 : count;
            for (int k = 0; k < n; k++) begin
                for (int i = 0; i < 8; i++) begin
                    raw.push_back('{3'd3, pkt_bytes[k][i], (i == 0) ? k : -1});
                    c = crc_step(c, pkt_bytes[k][i]);
                end
            end
            for (int i = 15; i >= 0; i--) raw.push_back('{3'd4, ~c[i], -1});
        end
        aborted = 0;
        run = 0;
        for (int j = 0; j < raw.size(); j++) begin
            if (raw[j].tag >= avail) begin
                aborted = 1;
                exp_q.push_back('{3'd6, 1'b0, 1'b0, 1'b1});
                break;
            end
            exp_q.push_back('{raw[j].code, raw[j].b, (raw[j].tag >= 0), 1'b0});
            run = raw[j].b ? run + 1 : 0;
            if (run == 6) begin
                exp_q.push_back('{3'd5, 1'b0, 1'b0, 1'b0});
                run = 0;
            end
        end
        if (aborted == 0) exp_q.push_back('{3'd6, 1'b0, 1'b0, 1'b0});
        exp_q.push_back('{3'd6, 1'b0, 1'b0, 1'b0});
        exp_q.push_back('{3'd0, 1'b1, 1'b0, 1'b0});
    endtask

    task automatic drive_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " idle state_val"}, 32'(state_val), 32'd0);
        check({tag, " idle serial_bit"}, 32'(serial_bit), 32'd1);
        check({tag, " idle busy"}, 32'(tx_busy), 32'd0);
        check({tag, " idle strobe"}, 32'(bit_strobe), 32'd0);
        check({tag, " idle done"}, 32'(tx_done), 32'd0);
        check({tag, " idle pop"}, 32'(fifo_pop), 32'd0);
    endtask

    // Send one packet and compare every clock against the model.
    task automatic run_packet(input string tag, input logic [3:0] pid, input logic [6:0] count,
                              input int avail, input int restart_cyc, input int reset_cyc);
        int    aborted, total, p, k, pops, exp_pops, last;
        string nm;
        build_model(pid, int'(count), avail, aborted);
        fifo_q.delete();
        for (int i = 0; i < avail; i++) fifo_q.push_back(pkt_bytes[i]);
        drive_fifo();
        exp_pops = 0;
        foreach (exp_q[i]) if (exp_q[i].pop) exp_pops++;
        pops = 0;
        last = exp_q.size() - 1;
        @(negedge clk);
        tx_pid = pid;
        tx_byte_count = count;
        tx_start = 1'b1;
        total = exp_q.size() * CPB;
        for (int cyc = 0; cyc < total; cyc++) begin
            @(negedge clk);
            tx_start = (cyc == restart_cyc);
            p = cyc / CPB;
            k = cyc % CPB;
            if (cyc == reset_cyc) begin
                #2 n_rst = 1'b0;
                #1;
                check({tag, " reset state_val"}, 32'(state_val), 32'd0);
                check({tag, " reset serial_bit"}, 32'(serial_bit), 32'd1);
                check({tag, " reset busy"}, 32'(tx_busy), 32'd0);
                check({tag, " reset strobe"}, 32'(bit_strobe), 32'd0);
                check({tag, " reset pop"}, 32'(fifo_pop), 32'd0);
                tx_start = 1'b0;
                fifo_q.delete();
                drive_fifo();
                @(negedge clk);
                n_rst = 1'b1;
                return;
            end
            nm = $sformatf("%s p%0d k%0d", tag, p, k);
            check({nm, " strobe"}, 32'(bit_strobe), 32'(k == 0));
            check({nm, " state_val"}, 32'(state_val), 32'(exp_q[p].code));
            if (exp_q[p].code != 3'd6) check({nm, " serial_bit"}, 32'(serial_bit), 32'(exp_q[p].b));
            check({nm, " busy"}, 32'(tx_busy), 32'(!(p == last && k == CPB - 1)));
            check({nm, " done"}, 32'(tx_done), 32'(p == last && k == CPB - 1 && aborted == 0));
            check({nm, " pop"}, 32'(fifo_pop), 32'(k == 0 && exp_q[p].pop));
            check({nm, " error"}, 32'(tx_error), 32'(k == 0 && exp_q[p].err));
            if (fifo_pop === 1'b1) begin
                pops++;
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            end
            drive_fifo();
        end
        tx_start = 1'b0;
        check({tag, " pop count"}, 32'(pops), 32'(exp_pops));
        for (int i = 0; i < 2 * CPB; i++) begin
            @(negedge clk);
            check_idle(tag);
        end
    endtask

    initial begin
        int          ab;
        logic [15:0] v;
        logic [15:0] c;

        fifo_q.delete();
        drive_fifo();

        // Hand-computed pins on the model itself.
        build_model(PID_ACK, 0, 0, ab);
        check("model ack length", 32'(exp_q.size()), 32'd19);
        v = '0;
        for (int i = 0; i < 16; i++) v = {v[14:0], exp_q[i].b};
        check("model ack bits", 32'(v), 32'h014B);
        build_model(PID_DATA0, 0, 0, ab);
        check("model data0 cnt0 length", 32'(exp_q.size()), 32'd35);
        pkt_bytes[0] = 8'hFF;
        build_model(PID_DATA0, 1, 1, ab);
        check("model ff length", 32'(exp_q.size()), 32'd45);
        check("model ff stuff slot", 32'(exp_q[20].code), 32'd5);
        c = 16'hFFFF;
        for (int i = 0; i < 8; i++) c = crc_step(c, 1'b1);
        check("model crc of ff", 32'(c), 32'h0000FF00);

        // Reset state.
        #12;
        check_idle("reset");
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check_idle("post reset");

        run_packet("ack", PID_ACK, 7'd0, 0, -1, -1);
        run_packet("data0 cnt0", PID_DATA0, 7'd0, 0, -1, -1);

        pkt_bytes[0] = 8'hFF;
        run_packet("data0 ff", PID_DATA0, 7'd1, 1, -1, -1);

        pkt_bytes[0] = 8'h3F; pkt_bytes[1] = 8'hFC; pkt_bytes[2] = 8'h81;
        run_packet("data1 cnt3", PID_DATA1, 7'd3, 3, -1, -1);

        pkt_bytes[0] = 8'h5A; pkt_bytes[1] = 8'hA5;
        run_packet("underrun", PID_DATA1, 7'd2, 1, -1, -1);

        run_packet("ack restart", PID_ACK, 7'd0, 0, 10 * CPB + 2, -1);
        run_packet("nak", PID_NAK, 7'd0, 0, -1, -1);

        for (int i = 0; i < 64; i++) pkt_bytes[i] = 8'(i * 37 + 5);
        run_packet("clamp", PID_DATA0, 7'd100, 64, -1, -1);

        pkt_bytes[0] = 8'h12; pkt_bytes[1] = 8'h34; pkt_bytes[2] = 8'h56; pkt_bytes[3] = 8'h78;
        run_packet("mid reset", PID_DATA0, 7'd4, 4, -1, 20 * CPB + 3);
        @(negedge clk);
        check_idle("after reset");
        run_packet("ack after reset", PID_ACK, 7'd0, 0, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_tx_sequencer.md
Name: usb_tx_sequencer

Overview:
Packet-level controller for the USB full-speed transmit path.
- Generates bit-period timing and drives the state code and raw bit stream that the NRZI line encoder consumes.
- Pulls payload bytes from the TX FIFO and builds SYNC, PID, DATA, CRC16 and EOP fields.
- Inserts stuffed bits after every six consecutive ones.

Parameters:
CLKS_PER_BIT, 8, clock cycles per bus bit period (96 MHz clk to 12 Mbps); must be >= 2
MAX_BYTES, 64, largest accepted payload; tx_byte_count above this value is clamped to it

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
tx_start  input  1  one-cycle request to transmit a packet; ignored while tx_busy=1
tx_pid  input  4  packet PID, captured on accepted tx_start
tx_byte_count  input  7  payload length, captured on accepted tx_start; used only for DATA PIDs
fifo_data  input  8  head byte of TX FIFO
fifo_empty  input  1  TX FIFO empty flag
fifo_pop  output  1  one-cycle pulse; consumes fifo_data
bit_strobe  output  1  one-cycle pulse on the first clock of every bit period; the encoder advances only on this pulse
serial_bit  output  1  raw (pre-NRZI) bit for the current bit period
state_val  output  3  field code for the current bit period: 0 IDLE/J, 1 SYNC, 2 PID, 3 DATA, 4 CRC, 5 STUFF, 6 EOP_SE0, 7 unused (treated as SE0 by the encoder)
tx_busy  output  1  high from accepted tx_start until tx_done or tx_error
tx_done  output  1  one-cycle pulse at the end of the final EOP J bit
tx_error  output  1  one-cycle pulse on FIFO underrun abort

Behaviour:
Reset values:
- FSM in IDLE; state_val=0; serial_bit=1.
- bit_strobe, fifo_pop, tx_busy, tx_done, tx_error all 0.
- Bit timer and ones counter = 0.
- Reset mid-packet returns to these values immediately, with no EOP.

Bit timing:
- The bit timer counts 0..CLKS_PER_BIT-1 while busy.
- bit_strobe is asserted when the timer is 0.
- serial_bit and state_val change only on bit_strobe cycles and are stable for the whole bit period.

Start:
- tx_start accepted in IDLE on edge N.
- Cycle N+1: first SYNC bit period begins, with bit_strobe=1 and tx_busy=1.

Field order and content (all fields sent LSB first):
- SYNC: 8 bits of 0x80.
- PID: 8 bits of {~tx_pid, tx_pid}.
- For DATA PIDs only (tx_pid[1:0]==2'b11): DATA for tx_byte_count bytes, then CRC for 16 bits.
- EOP_SE0: 2 bit periods.
- J: 1 bit period with state_val=0.
- tx_done pulses on the last clock of the J bit period; the FSM returns to IDLE on the next cycle, with tx_busy=0 on the same cycle tx_done is high.
- Non-DATA PIDs (handshake, token) send SYNC, PID, EOP only.
- A DATA PID with count 0 skips DATA and sends CRC only.

FIFO handshake:
- At the bit_strobe of bit 0 of each payload byte, if fifo_empty=0: load fifo_data into the shift register and pulse fifo_pop in the same cycle.
- If fifo_empty=1 at that point (underrun):
  - pulse tx_error;
  - go directly to EOP_SE0 for 2 bits and J for 1 bit;
  - then return to IDLE with no tx_done;
  - tx_busy drops when IDLE is reached.

CRC16:
- Polynomial 0x8005, register initialised to 0xFFFF at the start of the PID field, updated only on DATA bits (not stuffed bits).
- Per data bit b: fb = b ^ c[15]; c = {c[14:0],0} ^ (fb ? 0x8005 : 0).
- Transmitted as ~c[15] first, down to ~c[0].

Bit stuffing:
- A ones counter covers SYNC through CRC. It increments on each transmitted 1 and clears on each 0.
- When the counter reaches 6, the next bit period is STUFF (state_val=5, serial_bit=0); the field bit counter and CRC hold, and the ones counter clears.
- A stuff bit pending after the last CRC bit is still sent before EOP.
- Stuffing is never applied in EOP or J.

Simultaneous events:
- tx_start while busy is ignored and does not queue.
- tx_byte_count > MAX_BYTES is clamped.

Decomposition:
- Package usb_tx_pkg:
  - state_val encoding constants, as an enum typedef;
  - PID constants (ACK=4'b0010, NAK=4'b1010, DATA0=4'b0011, DATA1=4'b1011);
  - CRC16_POLY=16'h8005 and CRC16_INIT=16'hFFFF.
- One sub-module, usb_crc16, with ports clk, n_rst, clear, shift_en, bit_in, crc[15:0].
- Bit timer, ones counter and FSM are inline in usb_tx_sequencer.

Test Plan:
- ACK (tx_pid=4'b0010) -> 19 bit periods of 8 clocks (152 clocks).
  - serial_bit sequence 0000000 1 | 0100 1011; state_val 1×8, 2×8, 6×2, 0×1.
  - tx_done pulses on clock 152; no fifo_pop.
- DATA0, count 0 -> after PID, 16 CRC bits of 0 (state_val=4), then EOP; no fifo_pop; 35 bit periods total.
- DATA0, count 1, fifo_data=8'hFF:
  - PID ends with 1,1; STUFF bit (state_val=5, serial_bit=0) appears after DATA bit 3;
  - then 4 more DATA ones; exactly one fifo_pop, on the bit_strobe of DATA bit 0.
- DATA1, count 2, fifo_empty=1 before byte 2 -> one tx_error pulse; EOP_SE0×2 and J×1 follow; tx_done never asserts; tx_busy=0 afterwards.
- tx_start re-asserted during PID field -> ignored: packet unchanged, no second packet after tx_done.
- n_rst asserted mid-DATA -> same cycle: state_val=0, serial_bit=1, tx_busy=0; a fresh ACK afterwards transmits correctly.
